pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic pipeline-stage register between two CPU stages (e.g. ID->EXE, EXE->MEM), carrying control and data payload.
//  - Successor to the fixed per-field stage registers: parametrised widths, valid/ready handshake, optional 2-entry skid
//    buffer, flush-to-bubble and freeze.
//  - Saturating stall/bubble performance counters.
// PARAMETERS
//  CTRL_W  8   control bits (WB_EN, MEM_R_EN, EXE_CMD, ...); zeroed whenever slot is empty/flushed
//  DATA_W  96  data payload bits (PC, operands, immediates, dest); not cleared by flush
//  SKID    1   1: 2-entry skid buffer, in_ready registered; 0: single slot, in_ready combinational
//  CNT_W   16  perf counter width
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       synchronous, active-high reset
//  flush       in   1       discard all held beats (branch taken)
//  freeze      in   1       hold all state, block both handshakes (hazard stall)
//  in_valid    in   1       upstream beat valid
//  in_ready    out  1       stage accepts beat this cycle
//  in_ctrl     in   CTRL_W  upstream control
//  in_data     in   DATA_W  upstream payload
//  out_valid   out  1       downstream beat valid
//  out_ready   in   1       downstream accepts
//  out_ctrl    out  CTRL_W  control of head beat; 0 when head slot empty
//  out_data    out  DATA_W  payload of head beat
//  occupancy   out  2       beats held (0..2; max 1 when SKID=0)
//  cnt_clr     in   1       synchronous clear of both counters
//  stall_cnt   out  CNT_W   cycles with out_valid & ~out_ready
//  bubble_cnt  out  CNT_W   cycles with head slot empty (not in rst)
// BEHAVIOUR
//  - Storage: head slot M and skid slot S, each {v, ctrl, data}; in_fire=in_valid&in_ready, out_fire=out_valid&out_ready.
//  - Priority: rst > flush > freeze > normal.
//  - Reset: M.v=S.v=0, ctrl=0, data=0, occupancy=0, counters=0; out_valid=0, out_ctrl=0, out_data=0, in_ready=0 during rst.
//  - out_valid = M.v & ~freeze; out_ctrl = M.v ? M.ctrl : 0; out_data = M.data (always driven, even when frozen).
//  - SKID=1: in_ready = ~S.v & ~freeze (S.v is a flop, no comb path from out_ready).
//    EMPTY: in_fire -> ONE, M<=in.
//    ONE: in&out fire -> ONE, M<=in; in only -> TWO, S<=in; out only -> EMPTY.
//    TWO: in_ready=0; out_fire -> ONE, M<=S, S.v<=0.
//  - SKID=0: states EMPTY/ONE only; in_ready = (~M.v | out_ready) & ~freeze.
//  - Latency: 1 cycle in_fire -> out_valid when empty; throughput 1 beat/cycle with out_ready held high.
//  - Order preserved: beats leave in acceptance order; no beat duplicated or lost except by flush.
//  - flush: next cycle M.v=S.v=0 and both ctrl=0; data held; occupancy=0. A beat with in_fire in the flush cycle is
//    dropped. A head beat with out_fire in the flush cycle counts as delivered.
//  - freeze: no slot, occupancy or counter update (stall_cnt, bubble_cnt also hold); in_ready=0, out_valid=0.
//    Releasing freeze restores prior outputs unchanged.
//  - Counters: +1 per qualifying cycle; saturate at 2^CNT_W-1, no wrap; cnt_clr zeroes them (cnt_clr beats increment).
//    Counters are not cleared by flush.
// STRUCTURE
//  - Shared package pipe_pkg: occupancy state enum (OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2), counter saturate helper.
//  - Sub-module pipe_slot #(CTRL_W,DATA_W): one {v,ctrl,data} register with load/clear_v/hold; instantiated for M and S.
//  - Top: occupancy FSM, ready/valid logic, counters.
// TESTING
//  - Reset: rst high 2 cycles with in_valid=1 -> out_valid=0, out_ctrl=0, occupancy=0, counters 0; in_ready=1 cycle after rst drops.
//  - Streaming: SKID=1, out_ready=1, 8 beats data=0..7 back-to-back -> out_data 0..7 one cycle later, in_ready never low.
//  - Backpressure: out_ready=0 for 3 cycles mid-stream -> occupancy 1->2, in_ready=0, no beat lost/reordered,
//    stall_cnt=3.
//  - Flush: occupancy=2, flush with in_valid=1, ctrl=0xFF -> next cycle out_valid=0, out_ctrl=0, occupancy=0;
//    flushed-cycle beat never appears.
//  - Freeze: freeze 4 cycles with beat held -> out_valid=0, in_ready=0, out_data stable, counters unchanged;
//    release -> same beat delivered once.
//  - Saturation/mode: CNT_W=3, 10 stall cycles -> stall_cnt=7; cnt_clr -> 0. SKID=0 repeats streaming test,
//    occupancy never exceeds 1.

Source files
------------

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the generic pipeline-stage register.
//   - occ_e   : occupancy state of a stage (number of beats held).
//   - sat_inc : saturating increment used by the performance counters.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Number of beats currently held by a stage. The encoding equals the
  // occupancy count so the state can be exported directly.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Increment val by one unless it already holds the all-ones value of a
  // counter that is 'width' bits wide. Callers zero-extend into 64 bits and
  // truncate the result back to their own width.
  function automatic logic [63:0] sat_inc(input logic [63:0] val,
                                          input int unsigned width);
    logic [63:0] max_val;
    max_val = (64'd1 << width) - 64'd1;
    return (val >= max_val) ? val : (val + 64'd1);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid_if
//   Valid/ready beat channel between two pipeline stages.
//   Signals:
//     valid  producer -> consumer   beat present
//     ready  consumer -> producer   consumer takes the beat this cycle
//     ctrl   producer -> consumer   control bits of the beat
//     data   producer -> consumer   payload of the beat
//   Modports:
//     master : the producing side (drives valid/ctrl/data, samples ready)
//     slave  : the consuming side (samples valid/ctrl/data, drives ready)
// -----------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
);

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
//   One beat holding register {v, ctrl, data}.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset (clears v, ctrl and data)
//     i_load     capture i_ctrl/i_data and mark the slot valid
//     i_clear_v  empty the slot: v and ctrl go to 0, data is kept
//     i_ctrl     control bits to capture
//     i_data     payload to capture
//     o_v        slot holds a beat
//     o_ctrl     held control bits (0 whenever the slot is empty)
//     o_data     held payload (retained after the slot empties)
//   i_clear_v wins over i_load; with neither asserted the slot holds.
// -----------------------------------------------------------------------------
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear_v,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_v,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_v;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v    <= 1'b0;
      r_ctrl <= '0;
      r_data <= '0;
    end else if (i_clear_v) begin
      // Control is zeroed so an empty slot can never leak enables
      // downstream; payload is left alone to save toggling.
      r_v    <= 1'b0;
      r_ctrl <= '0;
    end else if (i_load) begin
      r_v    <= 1'b1;
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_v    = r_v;
  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic pipeline-stage register between two CPU stages with valid/ready
//   handshake, optional 2-entry skid buffer, flush-to-bubble, freeze and
//   saturating stall/bubble performance counters.
//   Parameters:
//     CTRL_W  control bits per beat (zeroed whenever the head slot is empty)
//     DATA_W  payload bits per beat (kept across flush)
//     SKID    1: head + skid slot, in_ready from a flop
//             0: head slot only, in_ready depends on out_ready
//     CNT_W   performance counter width
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     flush        drop every held beat (and any beat accepted this cycle)
//     freeze       hold all state and block both handshakes
//     in_if        upstream channel (slave side)
//     out_if       downstream channel (master side)
//     occupancy    beats held, 0..2
//     cnt_clr      synchronous clear of both counters
//     stall_cnt    cycles with out_valid & ~out_ready
//     bubble_cnt   cycles with the head slot empty
//   Priority of controls: rst > flush > freeze > normal operation.
// -----------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 96,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  pipe_stage_skid_if.slave  in_if,
  pipe_stage_skid_if.master out_if,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  occ_e              r_state;
  occ_e              w_state_next;

  logic              w_m_v;
  logic [CTRL_W-1:0] w_m_ctrl;
  logic [DATA_W-1:0] w_m_data;
  logic              w_s_v;
  logic [CTRL_W-1:0] w_s_ctrl;
  logic [DATA_W-1:0] w_s_data;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_fire;
  logic              w_out_fire;

  logic              w_m_load;
  logic              w_m_clear;
  logic              w_m_from_s;
  logic              w_s_load;
  logic              w_s_clear;
  logic [CTRL_W-1:0] w_m_ctrl_in;
  logic [DATA_W-1:0] w_m_data_in;

  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_bubble_cnt;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  generate
    if (SKID != 0) begin : g_ready_skid
      // The skid slot absorbs the beat accepted in the same cycle the
      // consumer stalls, so readiness only depends on the skid flop.
      assign w_in_ready = ~w_s_v & ~freeze & ~rst;
    end else begin : g_ready_single
      // Single slot: a full slot can take a new beat only while the
      // current one leaves, hence the combinational path from out_ready.
      assign w_in_ready = (~w_m_v | out_if.ready) & ~freeze & ~rst;
    end
  endgenerate

  assign w_out_valid = w_m_v & ~freeze & ~rst;
  assign w_in_fire   = in_if.valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_if.ready;

  // ---------------------------------------------------------------------------
  // Occupancy FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= OCC_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = OCC_EMPTY;
    end else if (!freeze) begin
      case (r_state)
        OCC_EMPTY: begin
          if (w_in_fire) begin
            w_state_next = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            // Unreachable without a skid slot because in_ready needs
            // out_ready there; guarded so the state can never overflow.
            w_state_next = (SKID != 0) ? OCC_TWO : OCC_ONE;
          end else if (!w_in_fire && w_out_fire) begin
            w_state_next = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (w_out_fire) begin
            w_state_next = OCC_ONE;
          end
        end
        default: begin
          w_state_next = OCC_EMPTY;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM: slot controls
  // ---------------------------------------------------------------------------
  always_comb begin
    w_m_load   = 1'b0;
    w_m_clear  = flush;
    w_m_from_s = 1'b0;
    w_s_load   = 1'b0;
    w_s_clear  = flush;
    if (!flush && !freeze) begin
      case (r_state)
        OCC_EMPTY: begin
          w_m_load = w_in_fire;
        end
        OCC_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_m_load = 1'b1;
          end else if (w_in_fire) begin
            w_s_load = 1'b1;
          end else if (w_out_fire) begin
            w_m_clear = 1'b1;
          end
        end
        OCC_TWO: begin
          // Head leaves: the older skid beat moves up, keeping order.
          if (w_out_fire) begin
            w_m_load   = 1'b1;
            w_m_from_s = 1'b1;
            w_s_clear  = 1'b1;
          end
        end
        default: begin
          w_m_clear = 1'b1;
          w_s_clear = 1'b1;
        end
      endcase
    end
  end

  assign w_m_ctrl_in = w_m_from_s ? w_s_ctrl : in_if.ctrl;
  assign w_m_data_in = w_m_from_s ? w_s_data : in_if.data;

  // ---------------------------------------------------------------------------
  // Storage slots
  // ---------------------------------------------------------------------------
  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_m_slot (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_m_load),
    .i_clear_v (w_m_clear),
    .i_ctrl    (w_m_ctrl_in),
    .i_data    (w_m_data_in),
    .o_v       (w_m_v),
    .o_ctrl    (w_m_ctrl),
    .o_data    (w_m_data)
  );

  generate
    if (SKID != 0) begin : g_skid_slot
      pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_s_slot (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_s_load),
        .i_clear_v (w_s_clear),
        .i_ctrl    (in_if.ctrl),
        .i_data    (in_if.data),
        .o_v       (w_s_v),
        .o_ctrl    (w_s_ctrl),
        .o_data    (w_s_data)
      );
    end else begin : g_no_skid_slot
      assign w_s_v    = 1'b0;
      assign w_s_ctrl = '0;
      assign w_s_data = '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (!freeze) begin
      if (w_out_valid && !out_if.ready) begin
        r_stall_cnt <= CNT_W'(sat_inc(64'(r_stall_cnt), CNT_W));
      end
      if (!w_m_v) begin
        r_bubble_cnt <= CNT_W'(sat_inc(64'(r_bubble_cnt), CNT_W));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_if.ready  = w_in_ready;
  assign out_if.valid = w_out_valid;
  assign out_if.ctrl  = w_m_v ? w_m_ctrl : '0;
  assign out_if.data  = w_m_data;
  assign occupancy    = rst ? 2'd0 : 2'(r_state);
  assign stall_cnt    = r_stall_cnt;
  assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Drives two stages from one stimulus stream: g_dut[0] without skid slot
//   (CNT_W=5) and g_dut[1] with skid slot (CNT_W=3). Each stage is mirrored
//   by a bounded FIFO model (capacity 1 or 2) plus the last head payload and
//   two saturating counters; every cycle all outputs are compared at the
//   falling edge. Directed phases add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

  localparam int CW = 8;
  localparam int DW = 32;
  localparam int BW = CW + DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          flush;
  logic          freeze;
  logic          in_valid;
  logic          out_ready;
  logic          cnt_clr;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  wire [1:0]         ir;
  wire [1:0]         ov;
  wire [1:0][CW-1:0] oc;
  wire [1:0][DW-1:0] od;
  wire [1:0][1:0]    occ;
  wire [1:0][4:0]    sc;
  wire [1:0][4:0]    bc;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int CNTW = (gi == 1) ? 3 : 5;
    logic [CNTW-1:0] s_cnt;
    logic [CNTW-1:0] b_cnt;

    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) in_bus ();
    pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) out_bus ();

    assign in_bus.valid  = in_valid;
    assign in_bus.ctrl   = in_ctrl;
    assign in_bus.data   = in_data;
    assign out_bus.ready = out_ready;

    assign ir[gi] = in_bus.ready;
    assign ov[gi] = out_bus.valid;
    assign oc[gi] = out_bus.ctrl;
    assign od[gi] = out_bus.data;
    assign sc[gi] = 5'(s_cnt);
    assign bc[gi] = 5'(b_cnt);

    pipe_stage_skid #(
      .CTRL_W (CW),
      .DATA_W (DW),
      .SKID   (gi),
      .CNT_W  (CNTW)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .freeze     (freeze),
      .in_if      (in_bus),
      .out_if     (out_bus),
      .occupancy  (occ[gi]),
      .cnt_clr    (cnt_clr),
      .stall_cnt  (s_cnt),
      .bubble_cnt (b_cnt)
    );
  end

  // Behavioural model: per stage a FIFO of beats {ctrl,data}, its fill level,
  // the payload last seen at the head, and the two counters.
  logic [BW-1:0] mf    [2][2];
  int            mcnt  [2];
  logic [DW-1:0] mlast [2];
  int            mst   [2];
  int            mbub  [2];
  bit            mvalid = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic int cap_of(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int max_of(input int k);
    return (k == 1) ? 7 : 31;
  endfunction

  task automatic chk(input string nm, input int k,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d] t=%0t: got %0h, expected %0h", nm, k, $time, act, exp);
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [BW-1:0] head;
      logic          e_rdy;
      logic          e_ov;
      logic [CW-1:0] e_oc;
      logic [DW-1:0] e_od;
      head  = mf[k][0];
      e_rdy = !rst && !freeze && ((mcnt[k] < cap_of(k)) || (k == 0 && out_ready));
      e_ov  = !rst && !freeze && (mcnt[k] > 0);
      e_oc  = (mcnt[k] > 0) ? head[BW-1:DW] : '0;
      e_od  = (mcnt[k] > 0) ? head[DW-1:0] : mlast[k];
      chk("in_ready",   k, 64'(ir[k]),  64'(e_rdy));
      chk("out_valid",  k, 64'(ov[k]),  64'(e_ov));
      chk("out_ctrl",   k, 64'(oc[k]),  64'(e_oc));
      chk("out_data",   k, 64'(od[k]),  64'(e_od));
      chk("occupancy",  k, 64'(occ[k]), 64'(mcnt[k]));
      chk("stall_cnt",  k, 64'(sc[k]),  64'(mst[k]));
      chk("bubble_cnt", k, 64'(bc[k]),  64'(mbub[k]));
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      bit rdy;
      bit ofire;
      bit ifire;
      rdy   = !freeze && ((mcnt[k] < cap_of(k)) || (k == 0 && out_ready));
      ofire = !freeze && (mcnt[k] > 0) && out_ready;
      ifire = in_valid && rdy;
      if (rst) begin
        mcnt[k]  = 0;
        mlast[k] = '0;
        mst[k]   = 0;
        mbub[k]  = 0;
      end else begin
        if (cnt_clr) begin
          mst[k]  = 0;
          mbub[k] = 0;
        end else if (!freeze) begin
          if (mcnt[k] > 0 && !out_ready && mst[k] < max_of(k)) mst[k]++;
          if (mcnt[k] == 0 && mbub[k] < max_of(k)) mbub[k]++;
        end
        if (flush) begin
          mcnt[k] = 0;
        end else if (!freeze) begin
          if (ofire) begin
            mf[k][0] = mf[k][1];
            mcnt[k]--;
          end
          if (ifire) begin
            mf[k][mcnt[k]] = {in_ctrl, in_data};
            mcnt[k]++;
          end
        end
        if (mcnt[k] > 0) mlast[k] = mf[k][0][DW-1:0];
      end
    end
    if (rst) mvalid = 1'b1;
  endtask

  // half(): falling edge plus per-cycle compare; rest(): rising edge, model
  // step, then 1 time unit so the caller can drive the next inputs.
  task automatic half();
    @(negedge clk);
    if (mvalid) compare_all();
  endtask

  task automatic rest();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    half();
    rest();
  endtask

  int seq = 0;

  initial begin
    rst = 1'b1; flush = 1'b0; freeze = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1; in_ctrl = 8'h5A; in_data = 32'hA5A5_0000;

    // Reset: two cycles with in_valid high
    cycle();
    half();
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 64'(ov[k]),  64'd0);
      chk("rst_in_ready",  k, 64'(ir[k]),  64'd0);
      chk("rst_out_ctrl",  k, 64'(oc[k]),  64'd0);
      chk("rst_out_data",  k, 64'(od[k]),  64'd0);
      chk("rst_occ",       k, 64'(occ[k]), 64'd0);
      chk("rst_stall",     k, 64'(sc[k]),  64'd0);
      chk("rst_bubble",    k, 64'(bc[k]),  64'd0);
    end
    rest();
    rst = 1'b0; in_valid = 1'b0;
    half();
    for (int k = 0; k < 2; k++) chk("ready_after_rst", k, 64'(ir[k]), 64'd1);
    rest();

    // Streaming: 8 back-to-back beats, data 0..7
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 32'(i); in_ctrl = 8'(i + 1);
      half();
      for (int k = 0; k < 2; k++) begin
        chk("stream_in_ready", k, 64'(ir[k]), 64'd1);
        if (i > 0) begin
          chk("stream_out_valid", k, 64'(ov[k]), 64'd1);
          chk("stream_out_data",  k, 64'(od[k]), 64'(i - 1));
        end
      end
      if (i > 0) chk("stream_occ_single", 0, 64'(occ[0]), 64'd1);
      rest();
    end
    in_valid = 1'b0;
    half();
    for (int k = 0; k < 2; k++) chk("stream_last_data", k, 64'(od[k]), 64'd7);
    rest();

    // Bubble counter pin: clear, then one empty cycle counts one bubble
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    half();
    for (int k = 0; k < 2; k++) chk("clr_bubble", k, 64'(bc[k]), 64'd0);
    rest();
    half();
    for (int k = 0; k < 2; k++) chk("bubble_one", k, 64'(bc[k]), 64'd1);
    rest();

    // Backpressure: out_ready low for 3 cycles mid-stream
    in_valid = 1'b1; in_data = 32'd100; in_ctrl = 8'h11;
    cycle();
    out_ready = 1'b0; in_data = 32'd101; in_ctrl = 8'h12;
    half();
    chk("bp_ready_skid", 1, 64'(ir[1]), 64'd1);
    chk("bp_ready_single", 0, 64'(ir[0]), 64'd0);
    rest();
    in_data = 32'd102; in_ctrl = 8'h13;
    half();
    chk("bp_occ_skid",    1, 64'(occ[1]), 64'd2);
    chk("bp_ready_full",  1, 64'(ir[1]),  64'd0);
    chk("bp_occ_single",  0, 64'(occ[0]), 64'd1);
    rest();
    cycle();
    out_ready = 1'b1;
    half();
    for (int k = 0; k < 2; k++) begin
      chk("bp_stall_cnt", k, 64'(sc[k]), 64'd3);
      chk("bp_head_data", k, 64'(od[k]), 64'd100);
    end
    rest();
    in_valid = 1'b0;
    repeat (3) cycle();

    // Flush with a full stage and a beat offered in the flush cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'd200; in_ctrl = 8'h21;
    cycle();
    in_data = 32'd201; in_ctrl = 8'h22;
    cycle();
    flush = 1'b1; in_ctrl = 8'hFF; in_data = 32'd202;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    half();
    for (int k = 0; k < 2; k++) begin
      chk("flush_out_valid", k, 64'(ov[k]),  64'd0);
      chk("flush_out_ctrl",  k, 64'(oc[k]),  64'd0);
      chk("flush_occ",       k, 64'(occ[k]), 64'd0);
      chk("flush_data_held", k, 64'(od[k]),  64'd200);
    end
    rest();
    out_ready = 1'b1;
    repeat (3) cycle();

    // Freeze for 4 cycles with one beat held
    in_valid = 1'b1; in_data = 32'd300; in_ctrl = 8'h3C; out_ready = 1'b0;
    cycle();
    freeze = 1'b1; in_data = 32'd301; in_ctrl = 8'h3D;
    for (int i = 0; i < 4; i++) begin
      half();
      for (int k = 0; k < 2; k++) begin
        chk("frz_out_valid", k, 64'(ov[k]), 64'd0);
        chk("frz_in_ready",  k, 64'(ir[k]), 64'd0);
        chk("frz_out_data",  k, 64'(od[k]), 64'd300);
      end
      rest();
    end
    freeze = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    half();
    for (int k = 0; k < 2; k++) begin
      chk("frz_release_valid", k, 64'(ov[k]), 64'd1);
      chk("frz_release_data",  k, 64'(od[k]), 64'd300);
    end
    rest();
    half();
    for (int k = 0; k < 2; k++) chk("frz_delivered_once", k, 64'(ov[k]), 64'd0);
    rest();

    // Saturation: 10 stall cycles, then clear
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0; in_valid = 1'b1; in_data = 32'd400; in_ctrl = 8'h44; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    repeat (10) cycle();
    half();
    chk("sat_stall_w3", 1, 64'(sc[1]), 64'd7);
    chk("sat_stall_w5", 0, 64'(sc[0]), 64'd10);
    rest();
    cnt_clr = 1'b1;
    cycle();
    cnt_clr = 1'b0;
    half();
    for (int k = 0; k < 2; k++) begin
      chk("sat_clr_stall",  k, 64'(sc[k]), 64'd0);
      chk("sat_clr_bubble", k, 64'(bc[k]), 64'd0);
    end
    rest();
    out_ready = 1'b1;
    cycle();

    // Randomised traffic against the model
    for (int t = 0; t < 600; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      freeze    = ($urandom_range(0, 9) == 0);
      flush     = !freeze && ($urandom_range(0, 19) == 0);
      cnt_clr   = !freeze && ($urandom_range(0, 29) == 0);
      in_ctrl   = 8'($urandom);
      seq++;
      in_data   = 32'h1000_0000 | 32'(seq);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1; freeze = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
